// File: rtl/beacon_tracker.sv
// beacon_tracker: turns the laser tower decoder's live signals into per-beacon
// records (center, width, revolution tag). Records are queued in a small
// first-word-fall-through FIFO. Each completed revolution's beacon count is
// published alongside.
module beacon_tracker #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] MIN_WIDTH = 16'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] position,
  input  logic        beacon_detection,
  input  logic        laser_sync,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_center,
  output logic [15:0] out_width,
  output logic [7:0]  out_rev,
  output logic        rev_strobe,
  output logic [3:0]  rev_beacons,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, IN_BEACON = 1'b1} state_t;

  logic          b_s1_q, b_s2_q, b_d_q;
  logic          s_s1_q, s_s2_q, s_d_q;
  logic [15:0]   p1_q, p2_q, pos_stable_q;
  logic [15:0]   start_pos_q;
  state_t        state_q, state_d;
  logic [7:0]    rev_cnt_q;
  logic [3:0]    run_cnt_q, rev_beacons_q;
  logic          rev_strobe_q, overflow_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [39:0]   mem_q [DEPTH];

  logic          b_rise, b_fall, sync_rise;
  logic          start_load, push_req;
  logic [15:0]   width_d, center_d;
  logic          full, pop, push_ok, drop;
  logic [3:0]    run_inc;
  logic [39:0]   head;

  assign b_rise    = b_s2_q & ~b_d_q;
  assign b_fall    = ~b_s2_q & b_d_q;
  assign sync_rise = s_s2_q & ~s_d_q;

  // Width wraps mod 2^16; center is the truncating midpoint, also wrapping.
  assign width_d  = pos_stable_q - start_pos_q;
  assign center_d = start_pos_q + (width_d >> 1);

  // Synchronizers, edge-detect delay flops and position debounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_s1_q       <= 1'b0;
      b_s2_q       <= 1'b0;
      b_d_q        <= 1'b0;
      s_s1_q       <= 1'b0;
      s_s2_q       <= 1'b0;
      s_d_q        <= 1'b0;
      p1_q         <= 16'd0;
      p2_q         <= 16'd0;
      pos_stable_q <= 16'd0;
    end else begin
      b_s1_q <= beacon_detection;
      b_s2_q <= b_s1_q;
      b_d_q  <= b_s2_q;
      s_s1_q <= laser_sync;
      s_s2_q <= s_s1_q;
      s_d_q  <= s_s2_q;
      p1_q   <= position;
      p2_q   <= p1_q;
      // Only take the bus once two consecutive samples agree.
      if (p1_q == p2_q) pos_stable_q <= p1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: a beacon ends on its falling edge or is abandoned at the index.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (b_rise) state_d = IN_BEACON;
      IN_BEACON: if (b_fall || sync_rise) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: latch the start position, request a push on a wide-enough beacon end.
  always_comb begin
    start_load = 1'b0;
    push_req   = 1'b0;
    case (state_q)
      IDLE:      start_load = b_rise;
      IN_BEACON: push_req   = b_fall && (width_d >= MIN_WIDTH);
      default:   ;
    endcase
  end

  // Full is the count MSB since DEPTH is a power of two.
  assign full    = count_q[AW];
  assign pop     = out_valid & out_ready;
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;
  assign run_inc = (run_cnt_q == 4'hF) ? 4'hF : run_cnt_q + 1'b1;

  // Beacon start position capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        start_pos_q <= 16'd0;
    else if (start_load) start_pos_q <= pos_stable_q;
  end

  // Revolution bookkeeping: tag, running count, published count, strobe, overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rev_cnt_q     <= 8'd0;
      run_cnt_q     <= 4'd0;
      rev_beacons_q <= 4'd0;
      rev_strobe_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      rev_strobe_q <= sync_rise;
      if (sync_rise) begin
        rev_cnt_q     <= rev_cnt_q + 1'b1;
        // A record pushed on the index cycle belongs to the ending revolution.
        rev_beacons_q <= push_ok ? run_inc : run_cnt_q;
        run_cnt_q     <= 4'd0;
      end else if (push_ok) begin
        run_cnt_q <= run_inc;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  // FIFO storage; the head entry is read combinationally (fall-through).
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {center_d, width_d, rev_cnt_q};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data outputs are forced to zero when empty so reset clears them without a clock.
  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign out_center  = out_valid ? head[39:24] : 16'd0;
  assign out_width   = out_valid ? head[23:8]  : 16'd0;
  assign out_rev     = out_valid ? head[7:0]   : 8'd0;
  assign rev_strobe  = rev_strobe_q;
  assign rev_beacons = rev_beacons_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_beacon_tracker.sv
// Scoreboard bench for beacon_tracker: stimulus pushes expected records,
// a negedge monitor pops and compares on every accepted handshake.
module tb_beacon_tracker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] position = 16'd0;
  logic        beacon_detection = 1'b0;
  logic        laser_sync = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        out_valid;
  logic [15:0] out_center, out_width;
  logic [7:0]  out_rev;
  logic        rev_strobe;
  logic [3:0]  rev_beacons;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  logic [39:0] exp_q[$];

  beacon_tracker #(.DEPTH(4), .MIN_WIDTH(16'd3)) dut (
    .clk(clk), .reset_n(reset_n), .position(position),
    .beacon_detection(beacon_detection), .laser_sync(laser_sync),
    .out_ready(out_ready), .out_valid(out_valid), .out_center(out_center),
    .out_width(out_width), .out_rev(out_rev), .rev_strobe(rev_strobe),
    .rev_beacons(rev_beacons), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input logic [15:0] c, input logic [15:0] w, input logic [7:0] r);
    exp_q.push_back({c, w, r});
  endtask

  // Full beacon with position held stable well around both edges.
  task automatic beacon(input logic [15:0] s, input logic [15:0] e);
    position = s;
    tick(4);
    beacon_detection = 1'b1;
    tick(5);
    position = e;
    tick(4);
    beacon_detection = 1'b0;
    tick(5);
  endtask

  task automatic sync_pulse();
    laser_sync = 1'b1;
    tick(4);
    laser_sync = 1'b0;
    tick(4);
  endtask

  // Monitor: one line per accepted record, compared against the scoreboard head.
  always @(negedge clk) begin
    if (rev_strobe) strobe_cnt++;
    if (reset_n && out_valid && out_ready) begin
      logic [39:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL record: got c=%0d w=%0d r=%0d expected none", out_center, out_width, out_rev);
      end else begin
        e = exp_q.pop_front();
        if ({out_center, out_width, out_rev} !== e) begin
          failures++;
          $display("FAIL record: got c=%0d w=%0d r=%0d expected c=%0d w=%0d r=%0d",
                   out_center, out_width, out_rev, e[39:24], e[23:8], e[7:0]);
        end else begin
          $display("ok   record: c=%0d w=%0d r=%0d", out_center, out_width, out_rev);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    // Reset state
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_center", out_center, 0);
    check("rst_strobe", rev_strobe, 0);
    check("rst_beacons", rev_beacons, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    tick(3);

    // Basic record and fall latency (out_ready held low to observe timing)
    position = 16'd100;
    tick(4);
    beacon_detection = 1'b1;
    tick(5);
    position = 16'd140;
    tick(4);
    expect_rec(16'd120, 16'd40, 8'd0);
    beacon_detection = 1'b0;
    tick(1);
    check("lat_edge_k", out_valid, 0);
    tick(1);
    check("lat_edge_k1", out_valid, 0);
    tick(1);
    check("lat_edge_k2", out_valid, 1);
    out_ready = 1'b1;
    tick(3);
    check("basic_drained", out_valid, 0);

    // Wrap-around and a too-narrow pulse
    expect_rec(16'd2, 16'd16, 8'd0);
    beacon(16'd65530, 16'd10);
    beacon(16'd200, 16'd202);
    check("narrow_none", out_valid, 0);

    // Beacon straddling the index: discarded, revolution 0 had 2 records
    s0 = strobe_cnt;
    position = 16'd300;
    tick(4);
    beacon_detection = 1'b1;
    tick(5);
    sync_pulse();
    position = 16'd350;
    tick(4);
    beacon_detection = 1'b0;
    tick(5);
    check("straddle_strobe", strobe_cnt - s0, 1);
    check("rev0_beacons", rev_beacons, 2);
    check("straddle_none", out_valid, 0);

    // Overflow: 5 beacons into a 4-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_rec(16'(1000 + i * 100 + 5 + i), 16'(10 + 2 * i), 8'd1);
      beacon(16'(1000 + i * 100), 16'(1000 + i * 100 + 10 + 2 * i));
    end
    check("ovf_set", overflow, 1);
    sync_pulse();
    check("rev1_beacons", rev_beacons, 4);

    // Push while full with a pop on the push edge
    position = 16'd900;
    tick(4);
    beacon_detection = 1'b1;
    tick(5);
    position = 16'd960;
    tick(4);
    expect_rec(16'd930, 16'd60, 8'd2);
    beacon_detection = 1'b0;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(3);
    check("pushpop_full", out_valid, 1);
    check("ovf_held", overflow, 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    out_ready = 1'b1;
    tick(8);
    check("ovf_drained", out_valid, 0);

    // Beacon fall and sync rise in the same cycle
    position = 16'd700;
    tick(4);
    beacon_detection = 1'b1;
    tick(5);
    position = 16'd720;
    tick(4);
    expect_rec(16'd710, 16'd20, 8'd2);
    beacon_detection = 1'b0;
    laser_sync = 1'b1;
    tick(5);
    laser_sync = 1'b0;
    tick(5);
    check("rev2_beacons", rev_beacons, 2);
    expect_rec(16'd803, 16'd6, 8'd3);
    beacon(16'd800, 16'd806);

    // Reset mid-beacon with two queued records
    out_ready = 1'b0;
    beacon(16'd1500, 16'd1510);
    beacon(16'd1600, 16'd1620);
    check("pre_rst_valid", out_valid, 1);
    position = 16'd1700;
    tick(4);
    beacon_detection = 1'b1;
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_width", out_width, 0);
    check("async_rst_beacons", rev_beacons, 0);
    exp_q.delete();
    beacon_detection = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);
    out_ready = 1'b1;
    expect_rec(16'd515, 16'd30, 8'd0);
    beacon(16'd500, 16'd530);
    tick(5);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beacon_tracker.md
# beacon_tracker

- Consumes the live outputs of the laser tower decoder: the quadrature position count, the beacon-present level and the per-revolution sync pulse.
- For every beacon seen during a revolution, produces one record: center angle (in encoder ticks), width and revolution tag.
- Queues records in a small FIFO drained through a valid/ready handshake by the SPI register interface.
- Also publishes the beacon count of each completed revolution.

## Interface

- DEPTH, 4, FIFO entries (power of 2, ≥2)
- MIN_WIDTH, 16'd3, narrowest accepted beacon in ticks; narrower pulses are discarded as noise

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- position  in  16  decoder tick count, asynchronous to clk, wraps mod 2^16
- beacon_detection  in  1  high while laser sees a beacon, asynchronous
- laser_sync  in  1  revolution index pulse, asynchronous, ≥3 clk wide
- out_ready  in  1  consumer accepts record
- out_valid  out  1  record available (FIFO non-empty)
- out_center  out  16  (start + width/2) mod 2^16
- out_width  out  16  (end − start) mod 2^16
- out_rev  out  8  revolution tag at beacon end
- rev_strobe  out  1  one-cycle pulse per detected sync rising edge
- rev_beacons  out  4  records accepted in last completed revolution, saturates at 15
- overflow  out  1  sticky: a record was dropped because FIFO full
- clr_overflow  in  1  synchronous clear of overflow

## Operation

- beacon_detection and laser_sync pass through 2-flop synchronizers (b_s1/b_s2, s_s1/s_s2) plus one delay flop each for edge detection.
- position is sampled every cycle into p1 and p2. pos_stable loads p1 only when p1 == p2, so a bus caught mid-transition is never used.
- State machine with two states, IDLE and IN_BEACON:
  - IDLE → IN_BEACON on a synchronized beacon rising edge; start_pos <= pos_stable.
  - IN_BEACON → IDLE on a synchronized beacon falling edge; width = pos_stable − start_pos (16-bit wrap).
  - If width ≥ MIN_WIDTH: push {center, width, rev_cnt}, where center = start_pos + (width >> 1) (16-bit wrap, truncating).
  - If width < MIN_WIDTH: discard the record.
  - IN_BEACON → IDLE on a sync rising edge with no falling edge in the same cycle: the beacon straddled the index, so discard it.
- Simultaneous beacon falling edge and sync rising edge:
  - The record is pushed with the pre-increment rev_cnt.
  - It counts toward the revolution that is ending.
- Simultaneous beacon rising edge and sync rising edge: enter IN_BEACON; the beacon belongs to the new revolution.
- On a sync rising edge:
  - rev_cnt increments (wraps 255 → 0).
  - rev_beacons <= this revolution's accepted count (including a same-cycle push).
  - The running count clears to 0.
  - rev_strobe pulses.
- FIFO is first-word-fall-through. A record leaves when out_valid && out_ready.
- Push while full:
  - With a pop in the same cycle: the push is accepted.
  - Without a pop: the record is dropped, overflow <= 1, and the running count does not increment.
- overflow priority: a set in the same cycle as clr_overflow wins.
- Reset mid-operation:
  - FIFO is emptied and the FSM returns to IDLE.
  - Every output returns to its reset value on assertion, with no clock edge needed.

## Timing

- All outputs are 0 in reset.
- Beacon falling-edge latency:
  - beacon_detection falls before clk edge k and is first captured in b_s1 at edge k.
  - The falling edge is detected in the cycle after edge k+1.
  - The push occurs at edge k+2; out_valid is high after edge k+2 (FIFO previously empty).
- Sync latency: the same sync path gives rev_strobe high for exactly one cycle, between edges k+2 and k+3.
- Position capture:
  - position must be stable for ≥2 clk before a beacon edge reaches b_s2 to be captured exactly.
  - Otherwise the last stable value is used.
- out_* are held constant while out_valid && !out_ready.

## Test plan

- position = 100 held, beacon high; position = 140, beacon low → one record: center = 120, width = 40, rev = 0; out_valid 3 edges after the fall.
- Wrap-around: start = 65530, end = 10 → width = 16, center = 2.
- Width 2 (< MIN_WIDTH) → no record and no count. Beacon spanning a sync edge → discarded; rev_strobe pulses and rev_cnt = 1.
- out_ready = 0, 5 valid beacons with DEPTH = 4 → 4 records retained in order, overflow = 1, rev_beacons = 4 at next sync. Then push with a simultaneous pop when full → accepted; overflow clears on clr_overflow.
- Beacon fall and sync rise in the same cycle → record rev = old tag, included in rev_beacons; next beacon tagged old + 1.
- reset_n low mid-beacon with 2 queued records → out_valid = 0 immediately; after release, the next beacon gives rev = 0 and the first record matches its own positions only.
